burst_ram_line_adapter: RTL and testbench
=========================================

Name: burst_ram_line_adapter

Overview:
- Converts single cache-line read/write requests from the cache/SoC side into BurstRAM burst transactions.
- Sits directly upstream of the BurstRAM instance and drives its br_* command/data interface.
- Read: gathers BURST_COUNT beats into one line. Write: splits one line into BURST_COUNT consecutive beats.
- One outstanding transaction at a time.

Parameters:
- DEPTH_BITWIDTH, 12: BurstRAM address width in DATA_BITWIDTH-wide words.
- DATA_BITWIDTH, 64: beat width. Must be a multiple of 8.
- BURST_COUNT, 4: beats per line. Must be a power of two, ≥2.
- TIMEOUT_CYCLES, 64: read watchdog limit. Used only with BURST_ADAPTER_TIMEOUT_EN.

Ports:
- clk  in  1  single clock, shared with BurstRAM.
- rst_n  in  1  asynchronous reset, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  adapter can accept a request.
- req_write  in  1  1 = line write, 0 = line read.
- req_addr  in  DEPTH_BITWIDTH  word address. Low log2(BURST_COUNT) bits are ignored and forced to 0.
- req_wr_line  in  DATA_BITWIDTH*BURST_COUNT  write line. Beat k = bits [k*DATA_BITWIDTH +: DATA_BITWIDTH].
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rd_line  out  DATA_BITWIDTH*BURST_COUNT  read line, same beat packing as req_wr_line.
- rsp_error  out  1  timeout flag, qualified by rsp_valid.
- br_cmd  out  1  0 = read, 1 = write.
- br_cmd_en  out  1  command strobe.
- br_addr  out  DEPTH_BITWIDTH  burst start address.
- br_wr_data  out  DATA_BITWIDTH  write beat.
- br_data_mask  out  DATA_BITWIDTH/8  byte mask, 1 = masked. Always 0.
- br_rd_data  in  DATA_BITWIDTH  read beat.
- br_rd_data_valid  in  1  read beat valid.
- br_busy  in  1  BurstRAM not ready for a command.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state = IDLE.
  - req_ready, rsp_valid, rsp_error, br_cmd_en, br_cmd = 0.
  - br_addr, br_wr_data, rsp_rd_line, beat counter = 0.
  - Reset asserted mid-transaction aborts it immediately; no rsp_valid is produced. BurstRAM is not reset by this block.
- States: IDLE, ISSUE, WR_BEATS, RD_WAIT, RESP.
- IDLE:
  - req_ready = !br_busy (combinational from state and br_busy).
  - On req_valid && req_ready: latch write flag, aligned address and write line. Next state is ISSUE.
  - req_valid with br_busy = 1 is held off (req_ready = 0) and is not consumed.
- ISSUE (exactly 1 cycle):
  - br_cmd_en = 1, br_cmd = latched write flag, br_addr = aligned address.
  - For writes, br_wr_data = beat 0 in this same cycle.
  - Next state: WR_BEATS if write, else RD_WAIT. Beat counter = 1 for writes, 0 for reads.
- WR_BEATS:
  - br_cmd_en = 0. br_wr_data = beat[counter] for cycles counter = 1..BURST_COUNT-1.
  - Leave to RESP after beat BURST_COUNT-1.
  - Write latency from acceptance cycle T: cmd at T+1, last beat at T+BURST_COUNT, rsp_valid at T+BURST_COUNT+1.
- RD_WAIT:
  - Each cycle with br_rd_data_valid = 1 stores br_rd_data into rsp_rd_line beat[counter], then counter += 1.
  - Beats need not be contiguous.
  - On the beat where counter = BURST_COUNT-1, go to RESP. rsp_valid rises the cycle after the last beat.
- RESP:
  - rsp_valid = 1 for exactly one cycle, then IDLE.
  - rsp_rd_line holds its value until the next read completes. It is unchanged by writes.
  - req_ready is 0 in RESP. Earliest next accept is the cycle after rsp_valid.
- br_rd_data_valid outside RD_WAIT is ignored. No capture, no state change.
- Beat counter width is log2(BURST_COUNT) bits plus margin; no wrap inside a transaction.
- br_data_mask is constant 0.

Optional Feature:
- Macro BURST_ADAPTER_TIMEOUT_EN.
- Defined:
  - RD_WAIT runs a cycle counter, cleared on entry and on every valid beat.
  - If it reaches TIMEOUT_CYCLES with no beat, go to RESP with rsp_error = 1 and rsp_rd_line = 0.
  - rsp_error clears on the next accepted request.
- Not defined:
  - No counter logic is built and rsp_error is tied to 0.
  - RD_WAIT waits indefinitely.

Test Plan:
- Reset: hold rst_n = 0 with random inputs → all outputs 0. Release with br_busy = 0 → req_ready = 1 the first cycle after release.
- Write: req_write = 1, req_addr = 0x013, beats 0x11..11 / 0x22..22 / 0x33..33 / 0x44..44 → br_cmd_en pulse with br_addr = 0x010 and beat0 = 0x11..11; beats 1–3 on the next 3 cycles; rsp_valid at T+5; br_data_mask = 0 throughout.
- Read with gaps: addr 0x020; BurstRAM returns 4 beats A, B, C, D with 2 idle cycles between B and C → rsp_rd_line = {D,C,B,A}; single rsp_valid the cycle after D.
- Busy hold-off: br_busy = 1 for 5 cycles with req_valid = 1 → req_ready = 0 and no br_cmd_en. Accepted in the first cycle br_busy = 0.
- Stray and reset-abort: br_rd_data_valid pulses in IDLE → no rsp_valid and rsp_rd_line unchanged. Assert rst_n = 0 after 2 of 4 read beats → outputs clear immediately; no rsp_valid after release.
- Timeout (macro on, TIMEOUT_CYCLES = 8): read with no beats → rsp_valid with rsp_error = 1 and rsp_rd_line = 0 at 8 cycles after ISSUE plus 1. Macro off: no rsp_valid after 200 cycles.

Source files
------------

// File: rtl/burst_ram_line_adapter_if.sv
// Request/response and BurstRAM command/data bundle for burst_ram_line_adapter.
// slave  : the adapter itself.
// master : whatever drives requests and models the BurstRAM (SoC side + memory).
interface burst_ram_line_adapter_if #(
  parameter int DEPTH_BITWIDTH = 12,
  parameter int DATA_BITWIDTH  = 64,
  parameter int BURST_COUNT    = 4
);
  logic                                 req_valid;
  logic                                 req_ready;
  logic                                 req_write;
  logic [DEPTH_BITWIDTH-1:0]            req_addr;
  logic [DATA_BITWIDTH*BURST_COUNT-1:0] req_wr_line;
  logic                                 rsp_valid;
  logic [DATA_BITWIDTH*BURST_COUNT-1:0] rsp_rd_line;
  logic                                 rsp_error;
  logic                                 br_cmd;
  logic                                 br_cmd_en;
  logic [DEPTH_BITWIDTH-1:0]            br_addr;
  logic [DATA_BITWIDTH-1:0]             br_wr_data;
  logic [DATA_BITWIDTH/8-1:0]           br_data_mask;
  logic [DATA_BITWIDTH-1:0]             br_rd_data;
  logic                                 br_rd_data_valid;
  logic                                 br_busy;

  modport slave (
    input  req_valid, req_write, req_addr, req_wr_line,
    input  br_rd_data, br_rd_data_valid, br_busy,
    output req_ready, rsp_valid, rsp_rd_line, rsp_error,
    output br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask
  );

  modport master (
    output req_valid, req_write, req_addr, req_wr_line,
    output br_rd_data, br_rd_data_valid, br_busy,
    input  req_ready, rsp_valid, rsp_rd_line, rsp_error,
    input  br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask
  );
endinterface

// File: rtl/burst_ram_line_adapter.sv
// Cache-line to BurstRAM burst adapter: one line request becomes one burst
// command plus BURST_COUNT write beats, or gathers BURST_COUNT read beats.
// One transaction outstanding at a time.
// Optional read watchdog: define BURST_ADAPTER_TIMEOUT_EN to build it.
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_IDLE     | waiting for a request; ready when BurstRAM is not busy
// ST_ISSUE    | one cycle: burst command strobe (and write beat 0)
// ST_WR_BEATS | driving write beats 1..BURST_COUNT-1
// ST_RD_WAIT  | collecting read beats (gaps allowed)
// ST_RESP     | one-cycle completion pulse
module burst_ram_line_adapter #(
  parameter int DEPTH_BITWIDTH = 12,
  parameter int DATA_BITWIDTH  = 64,
  parameter int BURST_COUNT    = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  burst_ram_line_adapter_if.slave  bus
);

  localparam int OFS_W = $clog2(BURST_COUNT);
  localparam int CNT_W = OFS_W + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_COUNT - 1);
  localparam logic [DEPTH_BITWIDTH-1:0] ALIGN_MASK = ~(DEPTH_BITWIDTH'(BURST_COUNT - 1));

  if (BURST_COUNT < 2 || (BURST_COUNT & (BURST_COUNT - 1)) != 0) begin : g_bad_burst
    $error("BURST_COUNT must be a power of two and at least 2");
  end
  if (DATA_BITWIDTH % 8 != 0) begin : g_bad_width
    $error("DATA_BITWIDTH must be a multiple of 8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE, ST_ISSUE, ST_WR_BEATS, ST_RD_WAIT, ST_RESP
  } state_e;

  state_e state_q, state_d;

  // alive_q gives the synchronous release: ready only after the first edge out of reset
  logic                                          alive_q;
  logic                                          wr_q;
  logic [DEPTH_BITWIDTH-1:0]                     addr_q;
  logic [CNT_W-1:0]                              cnt_q;
  logic [BURST_COUNT-1:0][DATA_BITWIDTH-1:0]     line_q;
  logic [BURST_COUNT-1:0][DATA_BITWIDTH-1:0]     rsp_line_q;
  logic [BURST_COUNT-1:0][DATA_BITWIDTH-1:0]     rd_line_d;
  logic [OFS_W-1:0]                              beat_idx;
  logic                                          accept;
  logic                                          rd_beat;
  logic                                          last_beat;
  logic                                          timeout;

  assign beat_idx  = cnt_q[OFS_W-1:0];
  assign last_beat = (cnt_q == LAST_BEAT);
  assign accept    = (state_q == ST_IDLE) && alive_q && !bus.br_busy && bus.req_valid;
  assign rd_beat   = (state_q == ST_RD_WAIT) && bus.br_rd_data_valid;

`ifdef BURST_ADAPTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_q;
  logic             rsp_err_q;

  // watchdog fires on the TIMEOUT_CYCLES-th consecutive beat-less RD_WAIT cycle
  assign timeout = (state_q == ST_RD_WAIT) && !bus.br_rd_data_valid && (tmo_q == '0);

  // down-counter, reloaded outside RD_WAIT and on every read beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else if (state_q != ST_RD_WAIT || bus.br_rd_data_valid) begin
      tmo_q <= TMO_LOAD;
    end else if (tmo_q != '0) begin
      tmo_q <= tmo_q - 1'b1;
    end
  end

  // error flag is sticky until the next request is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err_q <= 1'b0;
    end else if (accept) begin
      rsp_err_q <= 1'b0;
    end else if (timeout) begin
      rsp_err_q <= 1'b1;
    end
  end

  assign bus.rsp_error = rsp_err_q;
`else
  assign timeout       = 1'b0;
  assign bus.rsp_error = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (accept) state_d = ST_ISSUE;
      ST_ISSUE:    state_d = wr_q ? ST_WR_BEATS : ST_RD_WAIT;
      ST_WR_BEATS: if (last_beat) state_d = ST_RESP;
      ST_RD_WAIT:  if ((rd_beat && last_beat) || timeout) state_d = ST_RESP;
      ST_RESP:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // line buffer with the incoming read beat merged in at the current slot
  always_comb begin
    rd_line_d           = line_q;
    rd_line_d[beat_idx] = bus.br_rd_data;
  end

  // request latch, beat counter, read gather and completed-read line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive_q    <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
      line_q     <= '0;
      rsp_line_q <= '0;
    end else begin
      alive_q <= 1'b1;
      if (accept) begin
        wr_q   <= bus.req_write;
        addr_q <= bus.req_addr & ALIGN_MASK;
        line_q <= bus.req_wr_line;
      end
      case (state_q)
        ST_ISSUE:    cnt_q <= wr_q ? CNT_W'(1) : '0;
        ST_WR_BEATS: if (!last_beat) cnt_q <= cnt_q + 1'b1;
        ST_RD_WAIT: begin
          if (rd_beat) begin
            line_q <= rd_line_d;
            cnt_q  <= cnt_q + 1'b1;
            if (last_beat) rsp_line_q <= rd_line_d;
          end else if (timeout) begin
            rsp_line_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // outputs decoded from state
  always_comb begin
    bus.req_ready  = 1'b0;
    bus.rsp_valid  = 1'b0;
    bus.br_cmd     = 1'b0;
    bus.br_cmd_en  = 1'b0;
    bus.br_addr    = '0;
    bus.br_wr_data = '0;
    case (state_q)
      ST_IDLE:  bus.req_ready = alive_q && !bus.br_busy;
      ST_ISSUE: begin
        bus.br_cmd_en  = 1'b1;
        bus.br_cmd     = wr_q;
        bus.br_addr    = addr_q;
        bus.br_wr_data = wr_q ? line_q[0] : '0;
      end
      ST_WR_BEATS: bus.br_wr_data = line_q[beat_idx];
      ST_RESP:     bus.rsp_valid  = 1'b1;
      default: ;
    endcase
  end

  assign bus.rsp_rd_line  = rsp_line_q;
  assign bus.br_data_mask = '0;

endmodule

// File: tb/tb_burst_ram_line_adapter.sv
// Bench for burst_ram_line_adapter: table of line write/read-back vectors,
// hand-written corner sequences, then random traffic against a memory-level model.
module tb_burst_ram_line_adapter;

  localparam int DB  = 12;
  localparam int DW  = 64;
  localparam int BC  = 4;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  burst_ram_line_adapter_if #(.DEPTH_BITWIDTH(DB), .DATA_BITWIDTH(DW), .BURST_COUNT(BC)) bus ();

  burst_ram_line_adapter #(
    .DEPTH_BITWIDTH(DB), .DATA_BITWIDTH(DW), .BURST_COUNT(BC), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [255:0] last_read = '0;

  task automatic check(input string nm, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic quiet_inputs();
    bus.req_valid        = 1'b0;
    bus.req_write        = 1'b0;
    bus.req_addr         = '0;
    bus.req_wr_line      = '0;
    bus.br_rd_data       = '0;
    bus.br_rd_data_valid = 1'b0;
    bus.br_busy          = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, 256'(bus.req_ready), 256'(0));
    check({tag, "_rsp_valid"}, 256'(bus.rsp_valid), 256'(0));
    check({tag, "_rsp_error"}, 256'(bus.rsp_error), 256'(0));
    check({tag, "_cmd_en"}, 256'(bus.br_cmd_en), 256'(0));
    check({tag, "_cmd"}, 256'(bus.br_cmd), 256'(0));
    check({tag, "_br_addr"}, 256'(bus.br_addr), 256'(0));
    check({tag, "_wr_data"}, 256'(bus.br_wr_data), 256'(0));
    check({tag, "_rd_line"}, bus.rsp_rd_line, 256'(0));
    check({tag, "_mask"}, 256'(bus.br_data_mask), 256'(0));
  endtask

  // present a request at a drive point; returns at the drive point of the cycle after acceptance
  task automatic accept_req(input bit w, input logic [DB-1:0] a, input logic [255:0] line);
    bit ok = 1'b0;
    bus.req_valid   = 1'b1;
    bus.req_write   = w;
    bus.req_addr    = a;
    bus.req_wr_line = line;
    bus.br_busy     = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
      to_drive();
    end
    check("accept_within_bound", 256'(ok), 256'(1));
    to_drive();
    bus.req_valid = 1'b0;
  endtask

  task automatic wr_seq(input logic [DB-1:0] a, input logic [255:0] line, input logic [DB-1:0] exp_a);
    accept_req(1'b1, a, line);
    @(negedge clk);
    check("wr_cmd_en", 256'(bus.br_cmd_en), 256'(1));
    check("wr_cmd", 256'(bus.br_cmd), 256'(1));
    check("wr_addr", 256'(bus.br_addr), 256'(exp_a));
    check("wr_beat0", 256'(bus.br_wr_data), 256'(line[63:0]));
    check("wr_mask", 256'(bus.br_data_mask), 256'(0));
    for (int k = 1; k < BC; k++) begin
      to_drive();
      @(negedge clk);
      check("wr_cmd_en_low", 256'(bus.br_cmd_en), 256'(0));
      check("wr_beat", 256'(bus.br_wr_data), 256'(line[k*DW +: DW]));
      check("wr_rsp_early", 256'(bus.rsp_valid), 256'(0));
    end
    to_drive();
    @(negedge clk);
    check("wr_rsp_valid", 256'(bus.rsp_valid), 256'(1));
    check("wr_rsp_error", 256'(bus.rsp_error), 256'(0));
    check("wr_rd_line_kept", bus.rsp_rd_line, last_read);
    to_drive();
    @(negedge clk);
    check("wr_rsp_single", 256'(bus.rsp_valid), 256'(0));
    check("wr_ready_after", 256'(bus.req_ready), 256'(1));
    to_drive();
  endtask

  // gaps: nibble k = idle cycles before beat k
  task automatic rd_seq(input logic [DB-1:0] a, input logic [DB-1:0] exp_a, input logic [255:0] line,
                        input logic [15:0] gaps);
    accept_req(1'b0, a, rand_line());
    @(negedge clk);
    check("rd_cmd_en", 256'(bus.br_cmd_en), 256'(1));
    check("rd_cmd", 256'(bus.br_cmd), 256'(0));
    check("rd_addr", 256'(bus.br_addr), 256'(exp_a));
    for (int k = 0; k < BC; k++) begin
      for (int g = 0; g < int'(gaps[k*4 +: 4]); g++) begin
        to_drive();
        bus.br_rd_data_valid = 1'b0;
        bus.br_rd_data       = 64'(~k);
        @(negedge clk);
        check("rd_rsp_during_gap", 256'(bus.rsp_valid), 256'(0));
      end
      to_drive();
      bus.br_rd_data_valid = 1'b1;
      bus.br_rd_data       = line[k*DW +: DW];
      @(negedge clk);
      check("rd_rsp_during_beat", 256'(bus.rsp_valid), 256'(0));
    end
    to_drive();
    bus.br_rd_data_valid = 1'b0;
    @(negedge clk);
    check("rd_rsp_valid", 256'(bus.rsp_valid), 256'(1));
    check("rd_rsp_error", 256'(bus.rsp_error), 256'(0));
    check("rd_line", bus.rsp_rd_line, line);
    last_read = line;
    to_drive();
    @(negedge clk);
    check("rd_rsp_single", 256'(bus.rsp_valid), 256'(0));
    to_drive();
  endtask

  typedef struct {
    logic [DB-1:0] addr;
    logic [255:0]  line;
    logic [DB-1:0] exp_addr;
    logic [15:0]   gaps;
  } vec_t;

  vec_t vt[4];

  // random-traffic state
  logic [63:0]  bram [4096];
  logic [63:0]  refm [4096];

  initial begin
    bit           inflight, have_req, cur_w, pend_w, rd_done, emu_beat, exp_ready, exp_rsp, seen;
    logic [DB-1:0] pend_a;
    logic [255:0] pend_line, cur_line, l;
    int           cur_a, acc_cyc, last_beat_cyc, rd_left, rd_ptr, wr_left, wr_ptr, gap, cyc;

    vt[0].addr = 12'h013; vt[0].exp_addr = 12'h010; vt[0].gaps = 16'h0000;
    vt[0].line = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
    vt[1].addr = 12'h020; vt[1].exp_addr = 12'h020; vt[1].gaps = 16'h0200;
    vt[1].line = {64'hDDDD0000DDDD0003, 64'hCCCC0000CCCC0002, 64'hBBBB0000BBBB0001, 64'hAAAA0000AAAA0000};
    vt[2].addr = 12'hFFF; vt[2].exp_addr = 12'hFFC; vt[2].gaps = 16'h7777;
    vt[2].line = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h8000000000000001, 64'h7FFFFFFFFFFFFFFE};
    vt[3].addr = 12'h001; vt[3].exp_addr = 12'h000; vt[3].gaps = 16'h1301;
    vt[3].line = {64'h5A5A5A5A5A5A5A5A, 64'hA5A5A5A5A5A5A5A5, 64'h00000000FFFFFFFF, 64'hFFFFFFFF00000000};

    // reset with random inputs: every output held at 0
    rst_n = 1'b0;
    quiet_inputs();
    for (int i = 0; i < 4; i++) begin
      to_drive();
      bus.req_valid        = 1'($urandom);
      bus.req_write        = 1'($urandom);
      bus.req_addr         = 12'($urandom);
      bus.req_wr_line      = rand_line();
      bus.br_rd_data       = {$urandom, $urandom};
      bus.br_rd_data_valid = 1'($urandom);
      bus.br_busy          = 1'($urandom);
      @(negedge clk);
      check_all_zero("reset");
    end
    quiet_inputs();
    rst_n = 1'b1;
    to_drive();
    @(negedge clk);
    check("ready_after_release", 256'(bus.req_ready), 256'(1));
    to_drive();

    // table: write each line, then read it back with the row's gap pattern
    for (int r = 0; r < 4; r++) begin
      wr_seq(vt[r].addr, vt[r].line, vt[r].exp_addr);
      rd_seq(vt[r].addr, vt[r].exp_addr, vt[r].line, vt[r].gaps);
    end

    // busy hold-off: request waits, accepted in the first non-busy cycle
    bus.req_valid   = 1'b1;
    bus.req_write   = 1'b1;
    bus.req_addr    = 12'h100;
    bus.req_wr_line = rand_line();
    bus.br_busy     = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("busy_ready", 256'(bus.req_ready), 256'(0));
      check("busy_no_cmd", 256'(bus.br_cmd_en), 256'(0));
      to_drive();
    end
    bus.br_busy = 1'b0;
    @(negedge clk);
    check("busy_release_ready", 256'(bus.req_ready), 256'(1));
    to_drive();
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("busy_cmd_en", 256'(bus.br_cmd_en), 256'(1));
    check("busy_cmd_addr", 256'(bus.br_addr), 256'(12'h100));
    for (int i = 0; i < BC - 1; i++) begin
      to_drive();
      @(negedge clk);
    end
    to_drive();
    @(negedge clk);
    check("busy_rsp_valid", 256'(bus.rsp_valid), 256'(1));
    to_drive();

    // stray read beats while idle are ignored
    for (int i = 0; i < 3; i++) begin
      bus.br_rd_data_valid = 1'b1;
      bus.br_rd_data       = {$urandom, $urandom};
      @(negedge clk);
      check("stray_rsp_valid", 256'(bus.rsp_valid), 256'(0));
      check("stray_rd_line", bus.rsp_rd_line, last_read);
      check("stray_ready", 256'(bus.req_ready), 256'(1));
      to_drive();
    end
    bus.br_rd_data_valid = 1'b0;

    // reset in the middle of a read: outputs clear at once, no completion afterwards
    accept_req(1'b0, 12'h080, rand_line());
    @(negedge clk);
    check("abort_cmd_en", 256'(bus.br_cmd_en), 256'(1));
    for (int k = 0; k < 2; k++) begin
      to_drive();
      bus.br_rd_data_valid = 1'b1;
      bus.br_rd_data       = {$urandom, $urandom};
      @(negedge clk);
    end
    to_drive();
    bus.br_rd_data_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    last_read = '0;
    for (int i = 0; i < 10; i++) begin
      to_drive();
      bus.br_rd_data_valid = (i < 2);
      bus.br_rd_data       = {$urandom, $urandom};
      @(negedge clk);
      check("abort_no_rsp", 256'(bus.rsp_valid), 256'(0));
      check("abort_rd_line", bus.rsp_rd_line, 256'(0));
    end
    to_drive();
    bus.br_rd_data_valid = 1'b0;
    rd_seq(vt[1].addr, vt[1].exp_addr, vt[1].line, 16'h0000);

`ifdef BURST_ADAPTER_TIMEOUT_EN
    // read with no beats: watchdog completes it with an error and a cleared line
    accept_req(1'b0, 12'h040, rand_line());
    @(negedge clk);
    check("tmo_cmd_en", 256'(bus.br_cmd_en), 256'(1));
    for (int i = 1; i <= TMO; i++) begin
      to_drive();
      @(negedge clk);
      check("tmo_rsp_early", 256'(bus.rsp_valid), 256'(0));
    end
    to_drive();
    @(negedge clk);
    check("tmo_rsp_valid", 256'(bus.rsp_valid), 256'(1));
    check("tmo_rsp_error", 256'(bus.rsp_error), 256'(1));
    check("tmo_rd_line", bus.rsp_rd_line, 256'(0));
    last_read = '0;
    to_drive();
    @(negedge clk);
    check("tmo_rsp_single", 256'(bus.rsp_valid), 256'(0));
    check("tmo_error_held", 256'(bus.rsp_error), 256'(1));
    to_drive();
    wr_seq(12'h044, rand_line(), 12'h044);
`else
    // read with no beats: no watchdog, the adapter keeps waiting
    accept_req(1'b0, 12'h040, rand_line());
    @(negedge clk);
    check("hang_cmd_en", 256'(bus.br_cmd_en), 256'(1));
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      to_drive();
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    check("hang_no_rsp", 256'(seen), 256'(0));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_read = '0;
    to_drive();
`endif

    // random traffic: BurstRAM emulated by bram[], expected contents kept in refm[]
    for (int i = 0; i < 4096; i++) begin
      bram[i] = {$urandom, $urandom};
      refm[i] = bram[i];
    end
    quiet_inputs();
    inflight = 1'b0; have_req = 1'b0; rd_done = 1'b0;
    cur_w = 1'b0; pend_w = 1'b0; pend_a = '0; pend_line = '0; cur_line = '0;
    cur_a = 0; acc_cyc = 0; last_beat_cyc = 0;
    rd_left = 0; rd_ptr = 0; wr_left = 0; wr_ptr = 0; gap = 0; cyc = 0;
    while (cyc < 1500 || ((inflight || have_req) && cyc < 1700)) begin
      if (!have_req && cyc < 1500 && $urandom_range(0, 2) == 0) begin
        have_req  = 1'b1;
        pend_w    = 1'($urandom);
        pend_a    = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 63));
        pend_line = rand_line();
      end
      bus.req_valid   = have_req;
      bus.req_write   = pend_w;
      bus.req_addr    = pend_a;
      bus.req_wr_line = pend_line;
      bus.br_busy     = ($urandom_range(0, 3) == 0);
      emu_beat = 1'b0;
      if (rd_left > 0 && (gap >= 3 || $urandom_range(0, 1) == 0)) begin
        bus.br_rd_data_valid = 1'b1;
        bus.br_rd_data       = bram[rd_ptr];
        emu_beat = 1'b1;
        gap = 0;
      end else begin
        if (rd_left > 0) gap++;
        bus.br_rd_data_valid = (rd_left == 0) && ($urandom_range(0, 7) == 0);
        bus.br_rd_data       = {$urandom, $urandom};
      end
      @(negedge clk);

      exp_ready = !inflight && !bus.br_busy;
      check("rnd_ready", 256'(bus.req_ready), 256'(exp_ready));
      check("rnd_mask", 256'(bus.br_data_mask), 256'(0));
      check("rnd_cmd_en", 256'(bus.br_cmd_en), 256'(inflight && cyc == acc_cyc + 1));
      if (inflight && cyc == acc_cyc + 1) begin
        check("rnd_cmd", 256'(bus.br_cmd), 256'(cur_w));
        check("rnd_addr", 256'(bus.br_addr), 256'(cur_a));
        if (cur_w) check("rnd_beat0", 256'(bus.br_wr_data), 256'(cur_line[63:0]));
      end
      if (bus.br_cmd_en) begin
        if (bus.br_cmd) begin
          bram[int'(bus.br_addr)] = bus.br_wr_data;
          wr_ptr  = (int'(bus.br_addr) + 1) & 4095;
          wr_left = BC - 1;
        end else begin
          rd_ptr  = int'(bus.br_addr);
          rd_left = BC;
          gap     = 0;
        end
      end else if (wr_left > 0) begin
        if (inflight && cur_w)
          check("rnd_beat", 256'(bus.br_wr_data), 256'(cur_line[(cyc - acc_cyc - 1)*DW +: DW]));
        bram[wr_ptr] = bus.br_wr_data;
        wr_ptr  = (wr_ptr + 1) & 4095;
        wr_left--;
      end
      if (emu_beat) begin
        rd_ptr = (rd_ptr + 1) & 4095;
        rd_left--;
        if (rd_left == 0) begin
          rd_done       = 1'b1;
          last_beat_cyc = cyc;
        end
      end
      exp_rsp = inflight && (cur_w ? (cyc == acc_cyc + BC + 1) : (rd_done && cyc == last_beat_cyc + 1));
      check("rnd_rsp_valid", 256'(bus.rsp_valid), 256'(exp_rsp));
      if (exp_rsp) begin
        inflight = 1'b0;
        check("rnd_rsp_error", 256'(bus.rsp_error), 256'(0));
        if (!cur_w) begin
          for (int k = 0; k < BC; k++) l[k*DW +: DW] = refm[cur_a + k];
          last_read = l;
        end
      end
      check("rnd_rd_line", bus.rsp_rd_line, last_read);
      if (exp_ready && have_req) begin
        inflight = 1'b1;
        have_req = 1'b0;
        rd_done  = 1'b0;
        acc_cyc  = cyc;
        cur_w    = pend_w;
        cur_a    = int'(pend_a) & ~(BC - 1);
        cur_line = pend_line;
        if (cur_w) for (int k = 0; k < BC; k++) refm[cur_a + k] = cur_line[k*DW +: DW];
      end
      cyc++;
      to_drive();
    end
    check("rnd_drained", 256'(inflight || have_req), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
